fast_op_sequencer: RTL and testbench
====================================

FAST_OP_SEQUENCER -- requirements
Module: fast_op_sequencer

Interface
REQ-001 Parameter FIELD_W, default 10: template field width; the operator code occupies bits [FIELD_W-1 -: 3].
REQ-002 Parameter MAX_FIELDS, default 16: maximum number of fields per message.
REQ-003 Parameter MSG_ID_W, default 21: message ID width.
REQ-004 Parameter OP_W, derived = 1+MSG_ID_W+FIELD_W: op word layout is [OP_W-1] memory-write bit, [FIELD_W+MSG_ID_W-1:FIELD_W] message ID, [FIELD_W-1:0] template field.
REQ-005 Parameter CNT_W, derived = $clog2(MAX_FIELDS+1).
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 rstn  in  1  reset, asynchronous and active-low.
REQ-008 msg_valid  in  1  a message descriptor is offered.
REQ-009 msg_ready  out  1  the block accepts a descriptor.
REQ-010 msg_template  in  MAX_FIELDS*FIELD_W  flattened fields; field k occupies [k*FIELD_W +: FIELD_W].
REQ-011 msg_pmap  in  MAX_FIELDS  presence map; bit k belongs to field k.
REQ-012 msg_num_fields  in  CNT_W  number of valid fields.
REQ-013 stream_valid/stream_ready/stream_op  out/in/out  1/1/OP_W  channel for ops whose value is taken from the stream.
REQ-014 prev_valid/prev_ready/prev_op  out/in/out  1/1/OP_W  channel for ops whose value is taken from the previous-value dictionary.
REQ-015 done  out  1  one-cycle pulse when a message completes.
REQ-016 done_stream_cnt, done_prev_cnt  out  CNT_W each  op counts per channel for the completed message.
REQ-017 err_op  out  1  sticky flag for a reserved operator code.

Function
REQ-018 The FSM SHALL have three states: IDLE, WALK and DONE; msg_ready SHALL be 1 only in IDLE.
REQ-019 In IDLE with msg_valid=1, the block SHALL capture template, pmap and min(msg_num_fields, MAX_FIELDS), tag the message with the current msg_id, clear field index k and both per-channel counts, then go to WALK; if num_fields is 0 it SHALL go straight to DONE.
REQ-020 In WALK, field k SHALL be routed by its operator code as follows:
- 0 (none), 1 (constant), 3 (default): stream channel, write bit 0.
- 4 (delta): stream channel, write bit 1.
- 2 (copy), 5 (increment), 6 (tail): if pmap[k]=1, stream channel with write bit 1; otherwise prev channel with write bit 0.
- 7: dropped; err_op is set.
REQ-021 Each channel SHALL have a single output register; field k issues in a cycle when its target register is empty or is being drained (valid&&ready) in that same cycle, and otherwise WALK stalls with k unchanged.
REQ-022 A dropped field (code 7) SHALL advance k without stalling.
REQ-023 An issued op SHALL increment that channel's count; valid SHALL stay asserted and the op stable until ready.
REQ-024 With both readies held at 1, field k's op SHALL be valid k+1 cycles after the acceptance edge, giving a throughput of one field per cycle.
REQ-025 After the field at index num_fields-1 issues or drops, the FSM SHALL go to DONE.
REQ-026 In DONE, the block SHALL pulse done for one cycle with the final counts, increment msg_id modulo 2^MSG_ID_W, and return to IDLE.
REQ-027 Output registers still holding ops in DONE or IDLE SHALL keep their ops until drained; a new message MAY be accepted while they are held.
REQ-028 done_stream_cnt+done_prev_cnt SHALL equal num_fields minus the number of dropped fields.

Reset
REQ-029 While rstn=0, the block SHALL force the following, regardless of clk:
- FSM to IDLE; msg_ready to 1 once rstn deasserts.
- stream_valid, prev_valid, done and err_op to 0.
- stream_op, prev_op and both done counts to 0.
- msg_id to 0.
REQ-030 Reset asserted mid-message SHALL abort the message and discard any undrained ops.

Verification
REQ-031 Ops 0,1,3,4 in fields 0-3, num_fields=4, readies=1 -> four stream ops on consecutive cycles with write bits 0,0,0,1 and msg_id 0; done with counts 4/0.
REQ-032 Ops 2,5,6,2 with pmap=4'b0101 -> stream receives fields 0 and 2 with write bit 1; prev receives fields 1 and 3 with write bit 0; counts 2/2.
REQ-033 stream_ready=0 for 5 cycles during a 3-field all-stream message -> field 0 op held stable, no loss or duplication, done 5 cycles later than the unstalled run.
REQ-034 Field 1 has op 7, num_fields=3 -> err_op=1 and stays set, counts total 2; msg_num_fields=MAX_FIELDS+3 -> clamped to MAX_FIELDS ops.
REQ-035 MSG_ID_W=2, 5 back-to-back messages -> IDs 0,1,2,3,0; rstn pulsed low mid-WALK -> all valids 0 immediately, next message tagged ID 0.

Source files
------------

// File: rtl/fast_op_sequencer.sv
// Walks the fields of a message template and issues one op per field onto a
// stream channel or a previous-value channel, based on the field's operator code.
module fast_op_sequencer #(
    parameter int FIELD_W    = 10,
    parameter int MAX_FIELDS = 16,
    parameter int MSG_ID_W   = 21,
    parameter int OP_W       = 1 + MSG_ID_W + FIELD_W,
    parameter int CNT_W      = $clog2(MAX_FIELDS + 1)
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           msg_valid,
    output logic                           msg_ready,
    input  logic [MAX_FIELDS*FIELD_W-1:0]  msg_template,
    input  logic [MAX_FIELDS-1:0]          msg_pmap,
    input  logic [CNT_W-1:0]               msg_num_fields,
    output logic                           stream_valid,
    input  logic                           stream_ready,
    output logic [OP_W-1:0]                stream_op,
    output logic                           prev_valid,
    input  logic                           prev_ready,
    output logic [OP_W-1:0]                prev_op,
    output logic                           done,
    output logic [CNT_W-1:0]               done_stream_cnt,
    output logic [CNT_W-1:0]               done_prev_cnt,
    output logic                           err_op,
    output logic [1:0]                     dbg_state
);

    // Handshake: a channel transfers on a rising edge where valid && ready;
    // once valid rises, the op is held unchanged until that transfer.

    localparam int IDX_W = (MAX_FIELDS > 1) ? $clog2(MAX_FIELDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                               state;
    logic [MAX_FIELDS-1:0][FIELD_W-1:0]   tmpl_q;
    logic [MAX_FIELDS-1:0]                pmap_q;
    logic [CNT_W-1:0]                     nf_q;
    logic [CNT_W-1:0]                     k_q;
    logic [CNT_W-1:0]                     s_cnt;
    logic [CNT_W-1:0]                     p_cnt;
    logic [MSG_ID_W-1:0]                  msg_id;

    logic [IDX_W-1:0]   k_idx;
    logic [FIELD_W-1:0] fld;
    logic [2:0]         code;
    logic               pbit;
    logic               to_stream;
    logic               to_prev;
    logic               wr_bit;
    logic               drop;
    logic               s_free;
    logic               p_free;
    logic               issue_s;
    logic               issue_p;
    logic               advance;
    logic               last;
    logic [CNT_W-1:0]   s_cnt_nx;
    logic [CNT_W-1:0]   p_cnt_nx;
    logic [CNT_W-1:0]   num_clamped;

    assign msg_ready = (state == ST_IDLE);
    assign dbg_state = state;

    assign num_clamped = (msg_num_fields > CNT_W'(MAX_FIELDS)) ? CNT_W'(MAX_FIELDS)
                                                               : msg_num_fields;

    always_comb begin
        k_idx     = k_q[IDX_W-1:0];
        fld       = tmpl_q[k_idx];
        code      = fld[FIELD_W-1 -: 3];
        pbit      = pmap_q[k_idx];
        to_stream = 1'b0;
        to_prev   = 1'b0;
        wr_bit    = 1'b0;
        drop      = 1'b0;
        case (code)
            3'd0, 3'd1, 3'd3: to_stream = 1'b1;
            3'd4: begin
                to_stream = 1'b1;
                wr_bit    = 1'b1;
            end
            // Present fields carry a fresh value; absent ones reuse the dictionary.
            3'd2, 3'd5, 3'd6: begin
                if (pbit) begin
                    to_stream = 1'b1;
                    wr_bit    = 1'b1;
                end else begin
                    to_prev   = 1'b1;
                end
            end
            default: drop = 1'b1;
        endcase

        s_free   = !stream_valid || stream_ready;
        p_free   = !prev_valid || prev_ready;
        issue_s  = (state == ST_WALK) && to_stream && s_free;
        issue_p  = (state == ST_WALK) && to_prev && p_free;
        advance  = (state == ST_WALK) && (drop || issue_s || issue_p);
        last     = ((k_q + CNT_W'(1)) == nf_q);
        s_cnt_nx = s_cnt + CNT_W'(issue_s);
        p_cnt_nx = p_cnt + CNT_W'(issue_p);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= ST_IDLE;
            tmpl_q          <= '0;
            pmap_q          <= '0;
            nf_q            <= '0;
            k_q             <= '0;
            s_cnt           <= '0;
            p_cnt           <= '0;
            msg_id          <= '0;
            stream_valid    <= 1'b0;
            stream_op       <= '0;
            prev_valid      <= 1'b0;
            prev_op         <= '0;
            done            <= 1'b0;
            done_stream_cnt <= '0;
            done_prev_cnt   <= '0;
            err_op          <= 1'b0;
        end else begin
            done <= 1'b0;

            if (stream_valid && stream_ready) stream_valid <= 1'b0;
            if (prev_valid && prev_ready)     prev_valid   <= 1'b0;
            if (issue_s) begin
                stream_valid <= 1'b1;
                stream_op    <= {wr_bit, msg_id, fld};
            end
            if (issue_p) begin
                prev_valid <= 1'b1;
                prev_op    <= {wr_bit, msg_id, fld};
            end

            case (state)
                ST_IDLE: begin
                    if (msg_valid) begin
                        tmpl_q <= msg_template;
                        pmap_q <= msg_pmap;
                        nf_q   <= num_clamped;
                        k_q    <= '0;
                        s_cnt  <= '0;
                        p_cnt  <= '0;
                        if (num_clamped == '0) begin
                            state           <= ST_DONE;
                            done            <= 1'b1;
                            done_stream_cnt <= '0;
                            done_prev_cnt   <= '0;
                        end else begin
                            state <= ST_WALK;
                        end
                    end
                end
                ST_WALK: begin
                    if (advance) begin
                        k_q   <= k_q + CNT_W'(1);
                        s_cnt <= s_cnt_nx;
                        p_cnt <= p_cnt_nx;
                        if (drop) err_op <= 1'b1;
                        if (last) begin
                            state           <= ST_DONE;
                            done            <= 1'b1;
                            done_stream_cnt <= s_cnt_nx;
                            done_prev_cnt   <= p_cnt_nx;
                        end
                    end
                end
                ST_DONE: begin
                    msg_id <= msg_id + MSG_ID_W'(1);
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fast_op_sequencer.sv
// Randomized bench for fast_op_sequencer: a message-level reference model fills
// per-channel expected queues that a negedge monitor compares against transfers.
module tb_fast_op_sequencer;

    localparam int FW    = 10;
    localparam int MAXF  = 16;
    localparam int IDW   = 2;
    localparam int OPW   = 1 + IDW + FW;
    localparam int CW    = $clog2(MAXF + 1);
    localparam int DW    = 2 * CW + 1;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic                  msg_valid = 1'b0;
    logic                  msg_ready;
    logic [MAXF*FW-1:0]    msg_template = '0;
    logic [MAXF-1:0]       msg_pmap = '0;
    logic [CW-1:0]         msg_num_fields = '0;
    logic                  stream_valid;
    logic                  stream_ready = 1'b1;
    logic [OPW-1:0]        stream_op;
    logic                  prev_valid;
    logic                  prev_ready = 1'b1;
    logic [OPW-1:0]        prev_op;
    logic                  done;
    logic [CW-1:0]         done_stream_cnt;
    logic [CW-1:0]         done_prev_cnt;
    logic                  err_op;
    logic [1:0]            dbg_state;

    int total = 0;
    int bad   = 0;
    int ready_mode = 0;  // 0: both ready, 1: random, 2: stream held off, 3: both held off

    logic [OPW-1:0] exp_s[$];
    logic [OPW-1:0] exp_p[$];
    logic [DW-1:0]  exp_d[$];
    logic [IDW-1:0] mdl_id  = '0;
    logic           mdl_err = 1'b0;

    fast_op_sequencer #(
        .FIELD_W(FW), .MAX_FIELDS(MAXF), .MSG_ID_W(IDW)
    ) dut (
        .clk(clk), .rstn(rstn),
        .msg_valid(msg_valid), .msg_ready(msg_ready),
        .msg_template(msg_template), .msg_pmap(msg_pmap), .msg_num_fields(msg_num_fields),
        .stream_valid(stream_valid), .stream_ready(stream_ready), .stream_op(stream_op),
        .prev_valid(prev_valid), .prev_ready(prev_ready), .prev_op(prev_op),
        .done(done), .done_stream_cnt(done_stream_cnt), .done_prev_cnt(done_prev_cnt),
        .err_op(err_op), .dbg_state(dbg_state)
    );

    // clock / ready driving
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: begin stream_ready = 1'b1; prev_ready = 1'b1; end
            1: begin stream_ready = 1'($urandom_range(0, 1)); prev_ready = 1'($urandom_range(0, 1)); end
            2: begin stream_ready = 1'b0; prev_ready = 1'b1; end
            default: begin stream_ready = 1'b0; prev_ready = 1'b0; end
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard: transfers and done pulses checked away from the clock edge
    always @(negedge clk) begin
        if (rstn) begin
            if (stream_valid && stream_ready) begin
                if (exp_s.size() == 0) chk("stream_extra", 64'(stream_op), 64'hdead);
                else chk("stream_op", 64'(stream_op), 64'(exp_s.pop_front()));
            end
            if (prev_valid && prev_ready) begin
                if (exp_p.size() == 0) chk("prev_extra", 64'(prev_op), 64'hdead);
                else chk("prev_op", 64'(prev_op), 64'(exp_p.pop_front()));
            end
            if (done) begin
                if (exp_d.size() == 0) chk("done_extra", 64'(done), 64'd0);
                else chk("done_err_cnts", 64'({err_op, done_stream_cnt, done_prev_cnt}),
                         64'(exp_d.pop_front()));
            end
        end
    end

    function automatic logic [MAXF*FW-1:0] mk_tmpl(input logic [2:0] codes[MAXF]);
        logic [MAXF*FW-1:0] t;
        for (int k = 0; k < MAXF; k++) t[k*FW +: FW] = {codes[k], 7'($urandom)};
        return t;
    endfunction

    // Reference model: routing table applied per field, whole message at once.
    task automatic model_msg(input logic [MAXF*FW-1:0] t, input logic [MAXF-1:0] pm,
                             input int num);
        int n, s, p;
        logic [FW-1:0] f;
        n = (num > MAXF) ? MAXF : num;
        s = 0;
        p = 0;
        for (int k = 0; k < n; k++) begin
            f = t[k*FW +: FW];
            case (f[FW-1 -: 3])
                3'd0, 3'd1, 3'd3: begin exp_s.push_back({1'b0, mdl_id, f}); s++; end
                3'd4: begin exp_s.push_back({1'b1, mdl_id, f}); s++; end
                3'd7: mdl_err = 1'b1;
                default: begin
                    if (pm[k]) begin exp_s.push_back({1'b1, mdl_id, f}); s++; end
                    else begin exp_p.push_back({1'b0, mdl_id, f}); p++; end
                end
            endcase
        end
        exp_d.push_back({mdl_err, CW'(s), CW'(p)});
        mdl_id = mdl_id + 1'b1;
    endtask

    task automatic offer(input logic [MAXF*FW-1:0] t, input logic [MAXF-1:0] pm, input int num);
        int got = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (msg_ready) begin got = 1; break; end
        end
        chk("msg_ready_seen", 64'(got), 64'd1);
        model_msg(t, pm, num);
        msg_template   = t;
        msg_pmap       = pm;
        msg_num_fields = CW'(num);
        msg_valid      = 1'b1;
        @(posedge clk);
        #1 msg_valid = 1'b0;
    endtask

    // lat < 0 skips the latency comparison
    task automatic run_msg(input string tag, input logic [MAXF*FW-1:0] t,
                           input logic [MAXF-1:0] pm, input int num,
                           input bit stall, input int lat);
        int cyc = 0;
        int got = 0;
        offer(t, pm, num);
        fork
            begin
                if (stall) begin
                    @(posedge clk);
                    ready_mode = 2;
                    repeat (5) @(posedge clk);
                    ready_mode = 0;
                end
            end
            begin
                for (int i = 0; i < 300; i++) begin
                    @(negedge clk);
                    if (done) begin got = 1; break; end
                    cyc++;
                end
            end
        join
        chk({tag, "_done_seen"}, 64'(got), 64'd1);
        if (lat >= 0) chk({tag, "_latency"}, 64'(cyc), 64'(lat));
    endtask

    initial begin
        logic [2:0] codes[MAXF];
        logic [MAXF*FW-1:0] t;
        int got;

        #12;
        chk("rst_msg_ready", 64'(msg_ready), 64'd1);
        chk("rst_valids", 64'({stream_valid, prev_valid, done, err_op}), 64'd0);
        chk("rst_ops", 64'({stream_op, prev_op}), 64'd0);
        chk("rst_cnts", 64'({done_stream_cnt, done_prev_cnt}), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'd0);
        @(posedge clk);
        #2 rstn = 1'b1;

        // all-stream codes, readies high
        for (int k = 0; k < MAXF; k++) codes[k] = 3'd0;
        codes[0] = 3'd0; codes[1] = 3'd1; codes[2] = 3'd3; codes[3] = 3'd4;
        run_msg("basic", mk_tmpl(codes), '0, 4, 1'b0, 4);

        // presence-dependent routing
        codes[0] = 3'd2; codes[1] = 3'd5; codes[2] = 3'd6; codes[3] = 3'd2;
        run_msg("pmap", mk_tmpl(codes), 16'b0101, 4, 1'b0, 4);

        // stream back-pressure for five cycles
        codes[0] = 3'd1; codes[1] = 3'd3; codes[2] = 3'd0;
        run_msg("stall", mk_tmpl(codes), '0, 3, 1'b1, 8);

        // reserved code drops without stalling
        codes[0] = 3'd4; codes[1] = 3'd7; codes[2] = 3'd1;
        run_msg("drop", mk_tmpl(codes), '0, 3, 1'b0, 3);
        chk("err_sticky", 64'(err_op), 64'd1);

        // oversized count is clamped
        for (int k = 0; k < MAXF; k++) codes[k] = 3'($urandom_range(0, 1));
        run_msg("clamp", mk_tmpl(codes), '0, MAXF + 3, 1'b0, MAXF);
        run_msg("empty", mk_tmpl(codes), '0, 0, 1'b0, 0);

        // random messages under random back-pressure
        ready_mode = 1;
        for (int m = 0; m < 24; m++) begin
            for (int k = 0; k < MAXF; k++) codes[k] = 3'($urandom_range(0, 7));
            run_msg("rand", mk_tmpl(codes), 16'($urandom), int'($urandom_range(0, MAXF + 2)), 1'b0, -1);
        end
        ready_mode = 0;
        got = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_s.size() == 0 && exp_p.size() == 0) begin got = 1; break; end
        end
        chk("drain_rand", 64'(got), 64'd1);

        // reset asserted mid-walk aborts the message
        ready_mode = 3;
        for (int k = 0; k < MAXF; k++) codes[k] = 3'd0;
        offer(mk_tmpl(codes), '0, 8);
        repeat (3) @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        chk("midrst_valids", 64'({stream_valid, prev_valid, done, err_op}), 64'd0);
        chk("midrst_state", 64'(dbg_state), 64'd0);
        exp_s.delete();
        exp_p.delete();
        exp_d.delete();
        mdl_id  = '0;
        mdl_err = 1'b0;
        ready_mode = 0;
        @(posedge clk);
        #2 rstn = 1'b1;
        codes[0] = 3'd2; codes[1] = 3'd6;
        run_msg("after_rst", mk_tmpl(codes), 16'b01, 2, 1'b0, 2);

        got = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_s.size() == 0 && exp_p.size() == 0 && exp_d.size() == 0) begin got = 1; break; end
        end
        chk("final_drain", 64'(got), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
